// File: rtl/tpu_pkg.sv
// Shared TPU definitions: instruction layout, opcode values and loader error codes.
package tpu_pkg;

  localparam int INSTR_W   = 16;
  localparam int OPCODE_W  = 3;
  localparam int OPERAND_W = 13;

  typedef enum logic [OPCODE_W-1:0] {
    NOP_END     = 3'b000,
    LOAD_ADDR   = 3'b001,
    LOAD_WEIGHT = 3'b010,
    LOAD_INPUT  = 3'b011,
    COMPUTE     = 3'b100,
    STORE       = 3'b101
  } opcode_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_OVERFLOW = 2'b01;
  localparam logic [1:0] ERR_OPCODE   = 2'b10;
  localparam logic [1:0] ERR_CHECKSUM = 2'b11;

  // Opcodes 110 and 111 are unassigned and rejected by the loader.
  function automatic logic opcode_legal(input logic [OPCODE_W-1:0] op);
    return op <= STORE;
  endfunction

endpackage

// File: rtl/instr_loader.sv
// Host byte-stream loader: packs big-endian bytes into 16-bit instructions and fills the TPU instruction memory.
// Optional macro INSTR_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte after the END word.
module instr_loader #(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_start,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic [ADDR_W:0]    instr_count,
  output logic               prog_done,
  output logic               run_start,
  output logic               err,
  output logic [1:0]         err_code
);
  import tpu_pkg::*;

`ifdef INSTR_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_WRITE, S_DONE, S_ERR, S_CHK} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_WRITE, S_DONE, S_ERR} state_e;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    ptr_q, ptr_d;
  logic [7:0]           hi_q, hi_d;
  logic [INSTR_W-1:0]   word_q, word_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [INSTR_W-1:0]   wr_data_q, wr_data_d;
  logic [ADDR_W:0]      count_q, count_d;
  logic                 prog_done_q, prog_done_d;
  logic                 run_start_q, run_start_d;
  logic                 err_q, err_d;
  logic [1:0]           err_code_q, err_code_d;
  logic                 xfer;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]           xor_q, xor_d;
`endif

  // A restart request wins over any byte offered in the same cycle.
`ifdef INSTR_LOADER_CHECKSUM_EN
  assign byte_ready = (state_q == S_HI || state_q == S_LO || state_q == S_CHK) && !load_start;
`else
  assign byte_ready = (state_q == S_HI || state_q == S_LO) && !load_start;
`endif
  assign xfer = byte_valid && byte_ready;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hi_d        = hi_q;
    word_d      = word_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    count_d     = count_q;
    prog_done_d = prog_done_q;
    run_start_d = 1'b0;
    err_d       = err_q;
    err_code_d  = err_code_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    xor_d       = xor_q;
`endif
    if (load_start) begin
      state_d     = S_HI;
      ptr_d       = '0;
      count_d     = '0;
      prog_done_d = 1'b0;
      err_d       = 1'b0;
      err_code_d  = ERR_NONE;
`ifdef INSTR_LOADER_CHECKSUM_EN
      xor_d       = '0;
`endif
    end else begin
      case (state_q)
        S_HI: begin
          if (xfer) begin
            hi_d    = byte_in;
            state_d = S_LO;
`ifdef INSTR_LOADER_CHECKSUM_EN
            xor_d   = xor_q ^ byte_in;
`endif
          end
        end
        // The write strobe is registered here so it appears the cycle after the low byte.
        S_LO: begin
          if (xfer) begin
            word_d  = {hi_q, byte_in};
            state_d = S_WRITE;
`ifdef INSTR_LOADER_CHECKSUM_EN
            xor_d   = xor_q ^ byte_in;
`endif
            if (opcode_legal(hi_q[7 -: OPCODE_W])) begin
              wr_en_d   = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = {hi_q, byte_in};
            end
          end
        end
        S_WRITE: begin
          if (!opcode_legal(word_q[INSTR_W-1 -: OPCODE_W])) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = ERR_OPCODE;
          end else begin
            count_d = count_q + 1'b1;
            if (word_q == '0) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
              state_d     = S_CHK;
`else
              state_d     = S_DONE;
              prog_done_d = 1'b1;
              run_start_d = 1'b1;
`endif
            end else if (ptr_q == LAST_ADDR) begin
              state_d    = S_ERR;
              err_d      = 1'b1;
              err_code_d = ERR_OVERFLOW;
            end else begin
              ptr_d   = ptr_q + 1'b1;
              state_d = S_HI;
            end
          end
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (xfer) begin
            if (byte_in == xor_q) begin
              state_d     = S_DONE;
              prog_done_d = 1'b1;
              run_start_d = 1'b1;
            end else begin
              state_d    = S_ERR;
              err_d      = 1'b1;
              err_code_d = ERR_CHECKSUM;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      hi_q        <= '0;
      word_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      count_q     <= '0;
      prog_done_q <= 1'b0;
      run_start_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
`ifdef INSTR_LOADER_CHECKSUM_EN
      xor_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hi_q        <= hi_d;
      word_q      <= word_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      count_q     <= count_d;
      prog_done_q <= prog_done_d;
      run_start_q <= run_start_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      xor_q       <= xor_d;
`endif
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign instr_count = count_q;
  assign prog_done   = prog_done_q;
  assign run_start   = run_start_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed vector table, hand-written corner sequences and random programs.
// Honours INSTR_LOADER_CHECKSUM_EN the same way as the design.
module tb_instr_loader;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  typedef logic [7:0] bytes_q[$];

  typedef struct {
    logic [9:0][15:0] words;
    int               nWords;
    int               expCount;
    bit               expDone;
    bit               expErr;
    logic [1:0]       expCode;
  } vec_t;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               load_start = 1'b0;
  logic [7:0]         byte_in = 8'h00;
  logic               byte_valid = 1'b0;
  logic               byte_ready;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [15:0]        wr_data;
  logic [ADDR_W:0]    instr_count;
  logic               prog_done;
  logic               run_start;
  logic               err;
  logic [1:0]         err_code;

  int compared = 0;
  int mismatched = 0;

  logic [18:0] mWrites[$];
  int          accIdx = 0;
  int          runPulses = 0;
  bit          prevLo = 1'b0;

  logic [18:0] expWrites[$];
  int          expCount;
  int          expConsumed;
  bit          expDone;
  bit          expErr;
  logic [1:0]  expCode;

  vec_t vecs[7];

  instr_loader dut (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .instr_count (instr_count),
    .prog_done   (prog_done),
    .run_start   (run_start),
    .err         (err),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Passive monitor: collects writes and run pulses, and checks write latency against the low-byte handshake.
  always @(negedge clk) begin
    if (!reset || load_start) begin
      mWrites.delete();
      accIdx    = 0;
      runPulses = 0;
      prevLo    = 1'b0;
    end else begin
      if (prevLo) checkOutput("byte_ready during write cycle", {31'd0, byte_ready}, 32'd0);
      if (wr_en) begin
        checkOutput("wr_en one cycle after low byte", {31'd0, prevLo}, 32'd1);
        mWrites.push_back({wr_addr, wr_data});
      end
      if (run_start) runPulses++;
      prevLo = byte_valid && byte_ready && (accIdx % 2 == 1);
      if (byte_valid && byte_ready) accIdx++;
    end
  end

  function automatic bytes_q withChk(input bytes_q s);
    bytes_q r = s;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    foreach (s[i]) x ^= s[i];
    r.push_back(x);
`endif
    return r;
  endfunction

  // Reference model: walks the stream word by word following the loader's documented rules.
  task automatic modelRun(input bytes_q s);
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] xorAcc = 8'h00;
`endif
    logic [15:0] w;
    expWrites.delete();
    expCount = 0; expConsumed = 0; expDone = 0; expErr = 0; expCode = 2'b00;
    for (int i = 0; i < DEPTH; i++) begin
      if (2 * i + 1 >= s.size()) begin
        expConsumed = s.size();
        return;
      end
      w = {s[2*i], s[2*i+1]};
      expConsumed = 2 * i + 2;
`ifdef INSTR_LOADER_CHECKSUM_EN
      xorAcc ^= s[2*i] ^ s[2*i+1];
`endif
      if (w[15:13] >= 3'd6) begin
        expErr = 1; expCode = 2'b10;
        return;
      end
      expWrites.push_back({i[ADDR_W-1:0], w});
      expCount++;
      if (w == 16'h0000) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
        if (s.size() > expConsumed) begin
          expConsumed++;
          if (s[expConsumed-1] == xorAcc) expDone = 1;
          else begin expErr = 1; expCode = 2'b11; end
        end
`else
        expDone = 1;
`endif
        return;
      end
      if (i == DEPTH - 1) begin
        expErr = 1; expCode = 2'b01;
        return;
      end
    end
  endtask

  task automatic startLoad();
    @(posedge clk); #1;
    load_start = 1'b1;
    byte_valid = 1'b0;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  // Offers bytes in order, optionally with idle gaps; stops early once the loader finishes or aborts.
  task automatic sendBytes(input bytes_q s, input int gapPct, output int consumed);
    int guard = 0;
    consumed = 0;
    while (consumed < s.size()) begin
      if (gapPct > 0 && $urandom_range(99) < gapPct) byte_valid = 1'b0;
      else begin
        byte_valid = 1'b1;
        byte_in    = s[consumed];
      end
      @(negedge clk);
      if (byte_valid && byte_ready) consumed++;
      guard++;
      if (prog_done || err) break;
      if (guard > 8 * s.size() + 40) begin
        checkOutput("send timeout", consumed, s.size());
        break;
      end
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic compareAll(input string tag, input int consumed, input bit checkConsumed);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput({tag, " instr_count"}, 32'(instr_count), expCount);
    checkOutput({tag, " prog_done"}, {31'd0, prog_done}, {31'd0, expDone});
    checkOutput({tag, " err"}, {31'd0, err}, {31'd0, expErr});
    checkOutput({tag, " err_code"}, {30'd0, err_code}, {30'd0, expCode});
    checkOutput({tag, " run_start pulses"}, runPulses, expDone ? 1 : 0);
    if (expDone || expErr) checkOutput({tag, " byte_ready idle"}, {31'd0, byte_ready}, 32'd0);
    if (checkConsumed) checkOutput({tag, " bytes consumed"}, consumed, expConsumed);
    checkOutput({tag, " write count"}, mWrites.size(), expWrites.size());
    for (int i = 0; i < expWrites.size() && i < mWrites.size(); i++)
      checkOutput($sformatf("%s write%0d addr/data", tag, i), {13'd0, mWrites[i]}, {13'd0, expWrites[i]});
  endtask

  task automatic applyStimulus(input vec_t v, input string tag, input int gapPct);
    bytes_q s;
    int consumed;
    for (int i = 0; i < v.nWords; i++) begin
      s.push_back(v.words[i][15:8]);
      s.push_back(v.words[i][7:0]);
    end
    s = withChk(s);
    expWrites.delete();
    for (int i = 0; i < v.expCount; i++) expWrites.push_back({i[ADDR_W-1:0], v.words[i]});
    expCount = v.expCount; expDone = v.expDone; expErr = v.expErr; expCode = v.expCode;
    startLoad();
    sendBytes(s, gapPct, consumed);
    compareAll(tag, consumed, 1'b0);
  endtask

  initial begin
    bytes_q s;
    int consumed;
    logic [15:0] w;
    logic [7:0] x;

    #400_000;
    $display("[TB] FAIL global timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bytes_q s;
    int consumed;
    logic [15:0] w;
    int r;
    int n;
    logic [7:0] x;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset byte_ready", {31'd0, byte_ready}, 32'd0);
    checkOutput("reset wr_en", {31'd0, wr_en}, 32'd0);
    checkOutput("reset wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("reset wr_data", 32'(wr_data), 32'd0);
    checkOutput("reset instr_count", 32'(instr_count), 32'd0);
    checkOutput("reset prog_done", {31'd0, prog_done}, 32'd0);
    checkOutput("reset run_start", {31'd0, run_start}, 32'd0);
    checkOutput("reset err", {31'd0, err}, 32'd0);
    checkOutput("reset err_code", {30'd0, err_code}, 32'd0);
    reset = 1'b1;

    foreach (vecs[i]) vecs[i].words = '0;
    vecs[0].words[0] = 16'h200F; vecs[0].words[1] = 16'h4000; vecs[0].words[2] = 16'h0000;
    vecs[0].nWords = 3; vecs[0].expCount = 3; vecs[0].expDone = 1; vecs[0].expErr = 0; vecs[0].expCode = 2'b00;
    for (int i = 0; i < 8; i++) vecs[1].words[i] = 16'h2001 + 16'(i);
    vecs[1].nWords = 8; vecs[1].expCount = 8; vecs[1].expDone = 0; vecs[1].expErr = 1; vecs[1].expCode = 2'b01;
    vecs[2].words[0] = 16'hE000;
    vecs[2].nWords = 1; vecs[2].expCount = 0; vecs[2].expDone = 0; vecs[2].expErr = 1; vecs[2].expCode = 2'b10;
    vecs[3].words[0] = 16'h1234; vecs[3].words[1] = 16'hC123;
    vecs[3].nWords = 2; vecs[3].expCount = 1; vecs[3].expDone = 0; vecs[3].expErr = 1; vecs[3].expCode = 2'b10;
    for (int i = 0; i < 7; i++) vecs[4].words[i] = 16'h3001 + 16'(i);
    vecs[4].words[7] = 16'h0000;
    vecs[4].nWords = 8; vecs[4].expCount = 8; vecs[4].expDone = 1; vecs[4].expErr = 0; vecs[4].expCode = 2'b00;
    vecs[5].words[0] = 16'h0000;
    vecs[5].nWords = 1; vecs[5].expCount = 1; vecs[5].expDone = 1; vecs[5].expErr = 0; vecs[5].expCode = 2'b00;
    vecs[6].words[0] = 16'hA5A5; vecs[6].words[1] = 16'h0000;
    vecs[6].nWords = 2; vecs[6].expCount = 2; vecs[6].expDone = 1; vecs[6].expErr = 0; vecs[6].expCode = 2'b00;

    foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("vec%0d", i), 0);
    applyStimulus(vecs[0], "vec0 gaps", 50);
    applyStimulus(vecs[4], "vec4 gaps", 40);

    // Restart in the cycle after word 2's high byte, with a byte offered alongside load_start.
    startLoad();
    s = '{8'h20, 8'h0F, 8'h40};
    sendBytes(s, 0, consumed);
    checkOutput("pre-restart instr_count", 32'(instr_count), 32'd1);
    load_start = 1'b1;
    byte_valid = 1'b1;
    byte_in    = 8'h00;
    @(negedge clk);
    checkOutput("restart byte_ready", {31'd0, byte_ready}, 32'd0);
    @(posedge clk); #1;
    load_start = 1'b0;
    byte_valid = 1'b0;
    @(negedge clk);
    checkOutput("restart instr_count", 32'(instr_count), 32'd0);
    @(posedge clk); #1;
    s = withChk('{8'h30, 8'h01, 8'h00, 8'h00});
    expWrites.delete();
    expWrites.push_back({3'd0, 16'h3001});
    expWrites.push_back({3'd1, 16'h0000});
    expCount = 2; expDone = 1; expErr = 0; expCode = 2'b00; expConsumed = s.size();
    sendBytes(s, 0, consumed);
    compareAll("restart", consumed, 1'b1);

    // Asynchronous reset between clock edges while a load is in progress.
    startLoad();
    s = '{8'h20, 8'h0F, 8'h40};
    sendBytes(s, 0, consumed);
    checkOutput("pre-reset wr_data", 32'(wr_data), 32'h200F);
    byte_valid = 1'b1;
    byte_in    = 8'h00;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async reset byte_ready", {31'd0, byte_ready}, 32'd0);
    checkOutput("async reset wr_en", {31'd0, wr_en}, 32'd0);
    checkOutput("async reset wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("async reset wr_data", 32'(wr_data), 32'd0);
    checkOutput("async reset instr_count", 32'(instr_count), 32'd0);
    checkOutput("async reset prog_done", {31'd0, prog_done}, 32'd0);
    checkOutput("async reset run_start", {31'd0, run_start}, 32'd0);
    checkOutput("async reset err", {31'd0, err}, 32'd0);
    checkOutput("async reset err_code", {30'd0, err_code}, 32'd0);
    byte_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;

`ifdef INSTR_LOADER_CHECKSUM_EN
    startLoad();
    s = '{8'h20, 8'h0F, 8'h00, 8'h00, 8'h2F};
    expWrites.delete();
    expWrites.push_back({3'd0, 16'h200F});
    expWrites.push_back({3'd1, 16'h0000});
    expCount = 2; expDone = 1; expErr = 0; expCode = 2'b00; expConsumed = 5;
    sendBytes(s, 0, consumed);
    compareAll("checksum good", consumed, 1'b1);
    startLoad();
    s = '{8'h20, 8'h0F, 8'h00, 8'h00, 8'h00};
    expDone = 0; expErr = 1; expCode = 2'b11;
    sendBytes(s, 0, consumed);
    compareAll("checksum bad", consumed, 1'b1);
`endif

    for (int t = 0; t < 25; t++) begin
      s.delete();
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(99);
        if (r < 6) w = {3'($urandom_range(6, 7)), 13'($urandom)};
        else if (r < 14) w = 16'h0000;
        else w = {3'($urandom_range(0, 5)), 13'($urandom)};
        s.push_back(w[15:8]);
        s.push_back(w[7:0]);
      end
      if ($urandom_range(99) < 70) begin
        s.push_back(8'h00);
        s.push_back(8'h00);
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      x = 8'h00;
      foreach (s[i]) x ^= s[i];
      s.push_back(($urandom_range(99) < 70) ? x : 8'($urandom));
`else
      x = 8'h00;
`endif
      modelRun(s);
      startLoad();
      sendBytes(s, $urandom_range(0, 30), consumed);
      compareAll($sformatf("rand%0d", t), consumed, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
